arb_rr4: RTL and testbench

Four-requester round-robin arbiter that shares a single memory/bus port among up to four masters, such as instruction fetch, data load/store, debug and DMA. It selects one requester and drives the select of an internal 4:1 datapath mux, so that requester's address and write-enable reach the shared port. It holds the grant through a valid/ready handshake with the port, acknowledges the winner, then rotates priority. It sits between the CPU-side requesters and the memory interface.

---
 rtl/arb_pkg.sv | 5 +
 rtl/mux4.sv | 13 +
 rtl/arb_rr4.sv | 96 +++++++++
 tb/tb_arb_rr4.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: state encodings and requester count shared by the round-robin arbiter
package arb_pkg;
  localparam int NREQ = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mux4.sv
// mux4: parameterised 4:1 select used for the shared-port address and write-enable
module mux4 #(
  parameter int W = 1
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);
  assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/arb_rr4.sv
// arb_rr4: 4-way round-robin arbiter holding a grant through the bus handshake; ARB_TIMEOUT_EN adds a BUSY abort timer
module arb_rr4
  import arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [WIDTH-1:0]  addr0,
  input  logic [WIDTH-1:0]  addr1,
  input  logic [WIDTH-1:0]  addr2,
  input  logic [WIDTH-1:0]  addr3,
  input  logic [NREQ-1:0]   we,
  input  logic              bus_ready,
  output logic              bus_valid,
  output logic [WIDTH-1:0]  bus_addr,
  output logic              bus_we,
  output logic [NREQ-1:0]   gnt,
  output logic [1:0]        gnt_sel,
  output logic [NREQ-1:0]   ack,
  output logic              err
);
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel_n, idx, win;
  logic [NREQ-1:0] gnt_n, ack_n, rot;
  logic valid_n, err_n, tout;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt, cnt_n;
  assign tout = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_n;
  assign cnt_n = state == BUSY ? cnt + 1'b1 : '0;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tout = 1'b0;
`endif
  mux4 #(.W(WIDTH)) u_addr_mux (.sel(gnt_sel), .d0(addr0), .d1(addr1), .d2(addr2), .d3(addr3), .y(bus_addr));
  mux4 #(.W(1)) u_we_mux (.sel(gnt_sel), .d0(we[0]), .d1(we[1]), .d2(we[2]), .d3(we[3]), .y(bus_we));
  // rotate so bit 0 is the highest-priority requester, then pick the lowest set bit
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    idx = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) idx = 2'(i);
    win = ptr + idx;
  end
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = gnt_sel;
    ack_n   = '0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_n = BUSY;
        sel_n   = win;
        gnt_n   = NREQ'(1) << win;
      end
      BUSY: if (bus_ready || tout) begin
        state_n = DONE;
        ptr_n   = gnt_sel + 2'd1;
        ack_n   = gnt;
        err_n   = tout & ~bus_ready;
      end
      DONE: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    valid_n = state_n == BUSY;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= '0;
      gnt_sel   <= 2'd0;
      bus_valid <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      gnt_sel   <= sel_n;
      bus_valid <= valid_n;
      ack       <= ack_n;
      err       <= err_n;
    end
endmodule

// File: tb/tb_arb_rr4.sv
// tb_arb_rr4: directed self-checking bench for arb_rr4, sampling and driving on the falling edge
module tb_arb_rr4;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req, we, gnt, ack;
  logic [31:0] addr0, addr1, addr2, addr3, bus_addr;
  logic bus_ready, bus_valid, bus_we, err;
  logic [1:0] gnt_sel;
  int checks = 0;
  int errors = 0;
  int nv;
  logic seen;
  logic [3:0] exp_g;

  arb_rr4 #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .we(we), .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_addr(bus_addr),
    .bus_we(bus_we), .gnt(gnt), .gnt_sel(gnt_sel), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = 4'b0;
    bus_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    addr0 = 32'hA000_0000;
    addr1 = 32'hB111_1111;
    addr2 = 32'hC222_2222;
    addr3 = 32'hD333_3333;
    we = 4'b0101;
    do_reset;
    chk("rst_valid", bus_valid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", gnt_sel, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);

    req = 4'b0100;
    tick;
    chk("single_valid", bus_valid, 1);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_sel", gnt_sel, 2);
    chk("single_addr", bus_addr, 32'hC222_2222);
    chk("single_we", bus_we, 1);
    tick;
    chk("single_hold", bus_valid, 1);
    tick;
    chk("single_hold3", bus_valid, 1);
    bus_ready = 1'b1;
    tick;
    chk("single_ack", ack, 4'b0100);
    chk("single_done_valid", bus_valid, 0);
    chk("single_done_gnt", gnt, 4'b0100);
    bus_ready = 1'b0;
    req = 4'b0;
    tick;
    chk("single_idle_gnt", gnt, 0);
    chk("single_idle_ack", ack, 0);

    req = 4'b1001;
    tick;
    chk("wrap_gnt3", gnt, 4'b1000);
    chk("wrap_addr3", bus_addr, 32'hD333_3333);
    chk("wrap_we3", bus_we, 0);
    bus_ready = 1'b1;
    tick;
    chk("wrap_ack3", ack, 4'b1000);
    req = 4'b0001;
    tick;
    chk("wrap_idle", gnt, 0);
    tick;
    chk("wrap_gnt0", gnt, 4'b0001);
    chk("wrap_addr0", bus_addr, 32'hA000_0000);
    tick;
    chk("wrap_ack0", ack, 4'b0001);
    req = 4'b0;
    bus_ready = 1'b0;
    tick;

    req = 4'b0100;
    tick;
    chk("mid_gnt", gnt, 4'b0100);
    bus_ready = 1'b1;
    tick;
    chk("mid_ack", ack, 4'b0100);
    bus_ready = 1'b0;
    req = 4'b1000;
    tick;
    tick;
    chk("mid_busy_gnt", gnt, 4'b1000);
    rst_n = 1'b0;
    req = 4'b0;
    tick;
    chk("mid_rst_valid", bus_valid, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_ack", ack, 0);
    rst_n = 1'b1;
    req = 4'b1011;
    tick;
    chk("mid_ptr0_gnt", gnt, 4'b0001);
    do_reset;
    req = 4'b0010;
    tick;
    chk("mid_req1_gnt", gnt, 4'b0010);
    chk("mid_req1_sel", gnt_sel, 1);

    do_reset;
    req = 4'b1111;
    bus_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick;
      exp_g = 4'b0001 << ((k / 3) % 4);
      if (k % 3 == 0) begin
        chk("fair_gnt", gnt, exp_g);
        chk("fair_valid", bus_valid, 1);
      end else if (k % 3 == 1) begin
        chk("fair_ack", ack, exp_g);
      end else begin
        chk("fair_idle", {bus_valid, gnt}, 0);
      end
      req = ~ack;
    end
    req = 4'b0;
    bus_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stray_idle", {bus_valid, gnt, ack}, 0);
    end
    bus_ready = 1'b0;

    nv = 0;
    seen = 1'b0;
    req = 4'b0001;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 120 && !seen; i++) begin
      tick;
      if (ack != 4'b0) begin
        seen = 1'b1;
        chk("to_ack", ack, 4'b0001);
        chk("to_err", err, 1);
        req = 4'b0;
      end else if (bus_valid) nv++;
    end
    chk("to_seen", seen, 1);
    chk("to_len", nv, 16);
    tick;
    chk("to_err_pulse", err, 0);
    req = 4'b0001;
    for (int i = 0; i < 16; i++) tick;
    chk("same_valid", bus_valid, 1);
    bus_ready = 1'b1;
    tick;
    chk("same_ack", ack, 4'b0001);
    chk("same_err", err, 0);
`else
    for (int i = 0; i < 120; i++) begin
      tick;
      if (bus_valid && ack == 4'b0 && !err) nv++;
    end
    chk("noto_len", nv, 120);
    chk("noto_err", err, 0);
`endif
    do_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
